// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared fetch-predictor types and return address stack sizing
package core_types_pkg;

   localparam int RAS_ENTRIES      = 8;
   localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
   localparam int RAS_TARGET_WIDTH = 31;
   localparam int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1;

   // Snapshot held by the branch checkpoint array; entry contents are not saved.
   typedef struct packed {
      logic [RAS_INDEX_WIDTH-1:0] index;
      logic [RAS_COUNT_WIDTH-1:0] count;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - circular return address stack with checkpoint restore and same-cycle adjust
module ras_ckpt #(
   parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
   parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
   parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH,
   parameter int RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   input  logic                        restore_valid,
   input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
   input  logic [RAS_COUNT_WIDTH-1:0]  restore_count,
   output logic [RAS_TARGET_WIDTH-1:0] pop_target,
   output logic                        ras_empty,
   output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
   output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
   output logic                        overflow
);

   localparam logic [RAS_COUNT_WIDTH-1:0] FULL_CNT = RAS_COUNT_WIDTH'(RAS_ENTRIES);

   logic [RAS_TARGET_WIDTH-1:0] arr [RAS_ENTRIES];
   logic [RAS_INDEX_WIDTH-1:0]  ptr;
   logic [RAS_COUNT_WIDTH-1:0]  count;
   logic                        ovf_q;

   logic [RAS_INDEX_WIDTH-1:0]  b_ptr, nxt_ptr, wr_idx;
   logic [RAS_COUNT_WIDTH-1:0]  b_cnt, nxt_cnt;
   logic                        wr_en, nxt_ovf;

   // Restore replaces the base state so a redirected call/return lands in the same cycle.
   always_comb begin
      b_ptr   = restore_valid ? restore_index : ptr;
      b_cnt   = restore_valid ? restore_count : count;
      nxt_ptr = b_ptr;
      nxt_cnt = b_cnt;
      nxt_ovf = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = b_ptr;
      unique case ({push_valid, pop_valid})
         2'b10: begin
            wr_en   = 1'b1;
            wr_idx  = b_ptr + RAS_INDEX_WIDTH'(1);
            nxt_ptr = b_ptr + RAS_INDEX_WIDTH'(1);
            if (b_cnt == FULL_CNT) nxt_ovf = 1'b1;
            else                   nxt_cnt = b_cnt + RAS_COUNT_WIDTH'(1);
         end
         2'b01: begin
            if (b_cnt != '0) begin
               nxt_ptr = b_ptr - RAS_INDEX_WIDTH'(1);
               nxt_cnt = b_cnt - RAS_COUNT_WIDTH'(1);
            end
         end
         2'b11: begin
            // Return then call: the new return address replaces the current top.
            wr_en   = 1'b1;
            wr_idx  = b_ptr;
            nxt_cnt = (b_cnt == '0) ? RAS_COUNT_WIDTH'(1) : b_cnt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr   <= '0;
         count <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < RAS_ENTRIES; i++) arr[i] <= '0;
      end else begin
         ptr   <= nxt_ptr;
         count <= nxt_cnt;
         ovf_q <= nxt_ovf;
         if (wr_en) arr[wr_idx] <= push_target;
      end
   end

   assign pop_target = arr[ptr];
   assign ras_empty  = (count == '0);
   assign ras_index  = ptr;
   assign ras_count  = count;
   assign overflow   = ovf_q;

endmodule
